disp_mux_scan: RTL and testbench
================================

Name: disp_mux_scan

Overview:
- Parametrised multiplexed seven-segment scanner for NUM_DIGITS common-anode/cathode digits.
- Adds the following over the fixed 4-digit scanner:
  - tear-free double-buffered digit load;
  - 16-level PWM brightness;
  - per-digit blank and blink;
  - selectable enable/segment polarity.
- Sits between the crypto datapath display registers and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (2..16).
- PRESCALE_W, 16, prescaler width; digit slot = 2^PRESCALE_W clk cycles (>=4).
- BLINK_W, 6, frame-counter width; blink period = 2^BLINK_W frames.
- AN_ACTIVE_LOW, 1, 1: enabled digit driven 0; 0: driven 1.
- SEG_ACTIVE_LOW, 1, 1: lit segment driven 0; 0: driven 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture digit/dp/blank/blink inputs into pending buffer.
- digits  in  4*NUM_DIGITS  hex nibble per digit; digit k = digits[4k+3:4k].
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blank_mask  in  NUM_DIGITS  1 = digit dark.
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- brightness  in  4  PWM level; not buffered, applied immediately.
- an  out  NUM_DIGITS  one-hot digit enable (polarity per AN_ACTIVE_LOW).
- sseg  out  8  {dp,a,b,c,d,e,f,g}; sseg[7]=dp, sseg[6]=a .. sseg[0]=g.
- frame_done  out  1  one-cycle pulse at start of each frame.

Behaviour:
- Reset (synchronous, reset=1 at posedge clk):
  - prescaler=0, digit index=0, frame counter=0, pending valid=0;
  - shadow digits/dp/blink=0, shadow blank=all ones;
  - an=all disabled, sseg=all segments off, frame_done=0.
- Prescaler:
  - PRESCALE_W-bit counter, +1 every cycle, wraps.
  - tick = counter all ones.
- Index:
  - On tick, index+1; wraps NUM_DIGITS-1 -> 0.
  - wrap = tick while index==NUM_DIGITS-1.
- Frame counter: +1 on wrap; wraps at 2^BLINK_W.
- Buffering:
  - load=1 copies inputs to pending and sets pending valid.
  - On wrap with pending valid: pending -> shadow, pending valid cleared.
  - load and wrap in the same cycle: input data goes straight to shadow (newest wins), pending valid cleared.
  - Display changes only at frame boundaries; repeated loads within a frame keep the last one.
- PWM:
  - phase = counter[PRESCALE_W-1 -: 4].
  - Digit on when phase <= brightness: brightness 0 -> 1/16 duty, 15 -> full.
- Digit visible when all of these hold:
  - shadow blank bit = 0;
  - not (shadow blink bit = 1 and frame counter MSB = 1);
  - PWM on.
- Invisible digit: an still selects the slot, but all sseg bits are driven off (dp included).
- Glyphs, abcdefg active-high before polarity, values 0..F:
  - 0: 1111110, 1: 0110000, 2: 1101101, 3: 1111001
  - 4: 0110011, 5: 1011011, 6: 1011111, 7: 1110000
  - 8: 1111111, 9: 1111011, A: 1110111, b: 0011111
  - C: 1001110, d: 0111101, E: 1001111, F: 1000111
- Polarity:
  - dp lit = shadow dp bit.
  - Polarity inversion is applied last, per parameter.
- Latency:
  - an, sseg and frame_done are registered: they reflect the index/phase/shadow state of the previous cycle.
  - frame_done is high in the cycle an first selects digit 0 of the new frame.
- Mid-operation reset: immediately returns to the reset state; pending load discarded.
- brightness change: takes effect on the next PWM phase compare (1-cycle registered latency).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Shadow digits from NUM_DIGITS-1 downward whose nibble is 0 are forced dark, dp included, up to the first nonzero digit.
  - Digit 0 is never suppressed.
  - Suppression is evaluated on shadow data.
- Undefined: zeros display normally.

Test Plan:
(All scenarios use NUM_DIGITS=4, PRESCALE_W=4, BLINK_W=2, active-low polarities unless stated.)
- Reset, then run 200 cycles without load -> an scans 1110,1101,1011,0111 every 16 cycles; sseg=8'hFF throughout; frame_done pulses every 64 cycles.
- load with digits=16'h3A10, blank_mask=0, brightness=15 mid-frame -> old (blank) shadow shown until wrap. From the next frame:
  - digit0 sseg = ~{0,1111110} = 8'h81;
  - digit1 = ~{0,0110000} = 8'hCF;
  - digit2 = 8'h88 (A);
  - digit3 = 8'h86 (3).
- brightness=3 -> within each 16-cycle slot, sseg is lit for exactly the 4 cycles where phase 0..3 and 8'hFF for the remaining 12.
- blink_mask=4'b0010 -> digit1 lit for frames 0-1 and dark for frames 2-3 of each 4-frame period; other digits unaffected.
- load asserted in the same cycle as wrap with digits=16'h1111 -> digit 0 of the very next frame shows 1 (8'hCF).
- LEADING_ZERO_BLANK_EN defined, digits=16'h0050, dp_in=4'b1000 -> digits 3,2 dark (dp included); digit1 shows 5; digit0 shows 0.

Source files
------------

// File: rtl/disp_mux_scan_if.sv
// Display scanner bus: digit load side (master drives) and pin side (slave drives).
interface disp_mux_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic [3:0]                brightness;
  logic [NUM_DIGITS-1:0]     an;
  logic [7:0]                sseg;
  logic                      frame_done;

  modport master (
    output load, digits, dp_in, blank_mask, blink_mask, brightness,
    input  an, sseg, frame_done
  );

  modport slave (
    input  load, digits, dp_in, blank_mask, blink_mask, brightness,
    output an, sseg, frame_done
  );
endinterface

// File: rtl/disp_mux_scan.sv
// Multiplexed seven-segment scanner: double-buffered load, 16-level PWM, blank/blink, polarity.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module disp_mux_scan #(
  parameter int NUM_DIGITS     = 8,
  parameter int PRESCALE_W     = 16,
  parameter int BLINK_W        = 6,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  disp_mux_scan_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRESCALE_W-1:0]       r_cnt;
  logic [IDX_W-1:0]            r_idx;
  logic [BLINK_W-1:0]          r_frame;
  logic                        r_pend_v;
  logic [NUM_DIGITS-1:0][3:0]  r_pend_dig;
  logic [NUM_DIGITS-1:0]       r_pend_dp, r_pend_blank, r_pend_blink;
  logic [NUM_DIGITS-1:0][3:0]  r_sh_dig;
  logic [NUM_DIGITS-1:0]       r_sh_dp, r_sh_blank, r_sh_blink;
  logic [NUM_DIGITS-1:0]       r_an;
  logic [7:0]                  r_sseg;
  logic                        r_fd;

  logic                        w_tick, w_wrap, w_pwm_on, w_vis, w_fd;
  logic [3:0]                  w_phase, w_nib;
  logic [NUM_DIGITS-1:0]       w_lz, w_an_raw, w_an;
  logic [7:0]                  w_seg_raw, w_seg;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  assign w_tick   = &r_cnt;
  assign w_wrap   = w_tick && (r_idx == LAST_IDX);
  assign w_phase  = r_cnt[PRESCALE_W-1 -: 4];
  assign w_pwm_on = (w_phase <= bus.brightness);
  assign w_nib    = r_sh_dig[r_idx];
  assign w_fd     = (r_idx == '0) && (r_cnt == '0);

  // Suppression runs from the top digit down and stops at the first nonzero nibble.
  always_comb begin
    w_lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic v_run;
      v_run = 1'b1;
      for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
        v_run   = v_run & (r_sh_dig[k] == 4'h0);
        w_lz[k] = v_run;
      end
    end
`endif
  end

  always_comb begin
    w_vis = !r_sh_blank[r_idx]
            && !(r_sh_blink[r_idx] && r_frame[BLINK_W-1])
            && w_pwm_on
            && !w_lz[r_idx];
    w_seg_raw = w_vis ? {r_sh_dp[r_idx], glyph(w_nib)} : 8'h00;
    w_an_raw  = '0;
    w_an_raw[r_idx] = 1'b1;
    w_an  = (AN_ACTIVE_LOW  != 0) ? ~w_an_raw  : w_an_raw;
    w_seg = (SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame      <= '0;
      r_pend_v     <= 1'b0;
      r_pend_dig   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '1;
      r_pend_blink <= '0;
      r_sh_dig     <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '1;
      r_sh_blink   <= '0;
      r_an         <= AN_OFF;
      r_sseg       <= SEG_OFF;
      r_fd         <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_an   <= w_an;
      r_sseg <= w_seg;
      r_fd   <= w_fd;
      if (w_tick)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      if (w_wrap)
        r_frame <= r_frame + 1'b1;

      // A load coinciding with the wrap bypasses the pending buffer.
      if (w_wrap) begin
        if (bus.load) begin
          r_sh_dig   <= bus.digits;
          r_sh_dp    <= bus.dp_in;
          r_sh_blank <= bus.blank_mask;
          r_sh_blink <= bus.blink_mask;
        end else if (r_pend_v) begin
          r_sh_dig   <= r_pend_dig;
          r_sh_dp    <= r_pend_dp;
          r_sh_blank <= r_pend_blank;
          r_sh_blink <= r_pend_blink;
        end
        r_pend_v <= 1'b0;
      end else if (bus.load) begin
        r_pend_dig   <= bus.digits;
        r_pend_dp    <= bus.dp_in;
        r_pend_blank <= bus.blank_mask;
        r_pend_blink <= bus.blink_mask;
        r_pend_v     <= 1'b1;
      end
    end
  end

  assign bus.an         = r_an;
  assign bus.sseg       = r_sseg;
  assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_disp_mux_scan.sv
// Bench for disp_mux_scan (4 digits, 16-cycle slots, 4-frame blink) against a cycle-count model.
module tb_disp_mux_scan;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  disp_mux_scan_if #(.NUM_DIGITS(ND)) bus ();

  disp_mux_scan #(
    .NUM_DIGITS(ND), .PRESCALE_W(4), .BLINK_W(2),
    .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Model: n counts clocks since reset; scan position follows by division.
  int unsigned n;
  logic [15:0] sh_dig, pd_dig;
  logic [3:0]  sh_dp, sh_blank, sh_blink, pd_dp, pd_blank, pd_blink;
  logic        pend_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; pend_v = 1'b0;
    sh_dig = '0; sh_dp = '0; sh_blank = 4'hF; sh_blink = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.load = 1'b0;
    @(posedge clk); #1;
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_sseg", 32'(bus.sseg), 32'hFF);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic step();
    int unsigned idx, ph, fr;
    logic vis, lz;
    logic [3:0] one, e_an;
    logic [7:0] e_seg;
    idx = (n / 16) % 4;
    ph  = n % 16;
    fr  = (n / 64) % 4;
    lz  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0) begin
      lz = 1'b1;
      for (int k = 3; k >= int'(idx); k--)
        if (sh_dig[4*k +: 4] != 4'h0) lz = 1'b0;
    end
`endif
    vis = !sh_blank[idx] && !(sh_blink[idx] && fr >= 2) && (ph <= 32'(bus.brightness)) && !lz;
    e_seg = vis ? ~{sh_dp[idx], GLYPH[sh_dig[4*idx +: 4]]} : 8'hFF;
    one  = 4'b0001;
    e_an = ~(one << idx);
    @(posedge clk); #1;
    chk("an", 32'(bus.an), 32'(e_an));
    chk("sseg", 32'(bus.sseg), 32'(e_seg));
    chk("frame_done", 32'(bus.frame_done), 32'((n % 64) == 0));
    if ((n % 64) == 63) begin
      if (bus.load) begin
        sh_dig = bus.digits; sh_dp = bus.dp_in;
        sh_blank = bus.blank_mask; sh_blink = bus.blink_mask;
      end else if (pend_v) begin
        sh_dig = pd_dig; sh_dp = pd_dp; sh_blank = pd_blank; sh_blink = pd_blink;
      end
      pend_v = 1'b0;
    end else if (bus.load) begin
      pd_dig = bus.digits; pd_dp = bus.dp_in;
      pd_blank = bus.blank_mask; pd_blink = bus.blink_mask;
      pend_v = 1'b1;
    end
    n++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic load1(input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] bl, input logic [3:0] bk);
    bus.digits = d; bus.dp_in = dp; bus.blank_mask = bl; bus.blink_mask = bk;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0; bus.digits = '0; bus.dp_in = '0;
    bus.blank_mask = '0; bus.blink_mask = '0; bus.brightness = 4'd15;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle scan with blank shadow.
    run(200);

    // Mid-frame load, full brightness; old shadow persists until wrap.
    while ((n % 64) != 20) step();
    load1(16'h3A10, 4'b0000, 4'b0000, 4'b0000);
    run(130);

    // Reduced duty cycle.
    bus.brightness = 4'd3;
    run(64);
    bus.brightness = 4'd0;
    run(64);
    bus.brightness = 4'd15;

    // Blink on digit 1 with a dp pattern, over a full blink period.
    load1(16'h9C72, 4'b0101, 4'b0000, 4'b0010);
    run(4 * 64 + 10);

    // Repeated loads inside one frame: last one wins.
    load1(16'h4444, 4'b0000, 4'b0000, 4'b0000);
    run(5);
    load1(16'hBEEF, 4'b1111, 4'b0100, 4'b0000);
    run(80);

    // Load in the exact wrap cycle goes straight to shadow.
    while ((n % 64) != 63) step();
    load1(16'h1111, 4'b0000, 4'b0000, 4'b0000);
    run(20);

    // Leading zeros (suppressed only when the macro is defined).
    load1(16'h0050, 4'b1000, 4'b0000, 4'b0000);
    run(140);
    load1(16'h0000, 4'b1111, 4'b0000, 4'b0000);
    run(130);

    // Randomized loads, masks and brightness.
    for (int i = 0; i < 2500; i++) begin
      bus.load = ($urandom_range(0, 15) == 0);
      if (bus.load) begin
        bus.digits     = 16'($urandom);
        bus.dp_in      = 4'($urandom);
        bus.blank_mask = 4'($urandom & $urandom);
        bus.blink_mask = 4'($urandom);
      end
      if ($urandom_range(0, 31) == 0) bus.brightness = 4'($urandom);
      step();
    end
    bus.load = 1'b0;

    // Mid-operation reset discards a pending load.
    bus.brightness = 4'd15;
    while ((n % 64) != 30) step();
    load1(16'h8888, 4'b1111, 4'b0000, 4'b0000);
    run(3);
    @(negedge clk);
    do_reset();
    run(140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
